// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg: shared definitions for the instruction encoder/loader.
//   - op_e     : symbolic request op codes (values 17..31 are illegal)
//   - OPC_* / FN_* / RT_* / SA_* : MIPS opcode, funct and fixed-field values
//   - state_e  : loader FSM states
//   - enc_t    : encoder result (legal flag + 32-bit word)
//   - encode() : packs request fields into a MIPS word
package mips_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SUBU  = 5'd2,
    OP_SRAV  = 5'd3,
    OP_SRL   = 5'd4,
    OP_SLTU  = 5'd5,
    OP_BLTZ  = 5'd6,
    OP_BGEZ  = 5'd7,
    OP_J     = 5'd8,
    OP_ADDI  = 5'd9,
    OP_ADDIU = 5'd10,
    OP_SLTI  = 5'd11,
    OP_XORI  = 5'd12,
    OP_LUI   = 5'd13,
    OP_CLZ   = 5'd14,
    OP_CLO   = 5'd15,
    OP_SEB   = 5'd16
  } op_e;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
  localparam logic [5:0] OPC_REGIMM   = 6'b000001;
  localparam logic [5:0] OPC_J        = 6'b000010;
  localparam logic [5:0] OPC_ADDI     = 6'b001000;
  localparam logic [5:0] OPC_ADDIU    = 6'b001001;
  localparam logic [5:0] OPC_SLTI     = 6'b001010;
  localparam logic [5:0] OPC_XORI     = 6'b001110;
  localparam logic [5:0] OPC_LUI      = 6'b001111;
  localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OPC_SPECIAL3 = 6'b011111;

  // Function codes
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_CLZ   = 6'b100000;
  localparam logic [5:0] FN_CLO   = 6'b100001;
  localparam logic [5:0] FN_BSHFL = 6'b100000;

  // REGIMM selectors live in the rt field; SEB's sub-op lives in shamt
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;
  localparam logic [4:0] SA_SEB  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic logic [31:0] r_type(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sa, input logic [5:0] fn);
    return {opc, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Fields not used by an op are forced to zero regardless of the request.
  function automatic enc_t encode(input logic [4:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [4:0] sa, input logic [15:0] imm,
                                  input logic [25:0] target);
    enc_t e;
    e.legal = 1'b1;
    e.word  = '0;
    case (op)
      OP_ADD:   e.word = r_type(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_ADD);
      OP_SUB:   e.word = r_type(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUB);
      OP_SUBU:  e.word = r_type(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUBU);
      OP_SRAV:  e.word = r_type(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SRAV);
      OP_SRL:   e.word = r_type(OPC_SPECIAL, 5'd0, rt, rd, sa, FN_SRL);
      OP_SLTU:  e.word = r_type(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SLTU);
      OP_BLTZ:  e.word = i_type(OPC_REGIMM, rs, RT_BLTZ, imm);
      OP_BGEZ:  e.word = i_type(OPC_REGIMM, rs, RT_BGEZ, imm);
      OP_J:     e.word = {OPC_J, target};
      OP_ADDI:  e.word = i_type(OPC_ADDI, rs, rt, imm);
      OP_ADDIU: e.word = i_type(OPC_ADDIU, rs, rt, imm);
      OP_SLTI:  e.word = i_type(OPC_SLTI, rs, rt, imm);
      OP_XORI:  e.word = i_type(OPC_XORI, rs, rt, imm);
      OP_LUI:   e.word = i_type(OPC_LUI, 5'd0, rt, imm);
      OP_CLZ:   e.word = r_type(OPC_SPECIAL2, rs, rt, rd, 5'd0, FN_CLZ);
      OP_CLO:   e.word = r_type(OPC_SPECIAL2, rs, rt, rd, 5'd0, FN_CLO);
      OP_SEB:   e.word = r_type(OPC_SPECIAL3, 5'd0, rt, rd, SA_SEB, FN_BSHFL);
      default:  e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (flushes contents)
//   push, wdata   : write a word (ignored when full, even if popping)
//   pop           : drop the head word (ignored when empty)
//   rdata         : current head word, zero when empty
//   full, empty   : occupancy flags
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head must be visible the cycle after a push, so the read is asynchronous.
  assign rdata = empty ? '0 : mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: encodes symbolic instruction requests into 32-bit
// MIPS words, buffers them and writes them to instruction memory at
// consecutive word addresses starting from a latched base address.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   start, base_addr             : begin a session at base_addr (low 2 bits cleared)
//   req_valid/req_ready/req_last : request handshake, last marks session end
//   req_op .. req_target         : symbolic instruction fields
//   imem_we/imem_ready           : memory write handshake
//   imem_addr, imem_wdata        : write address and encoded word
//   busy, done                   : session active, one-cycle end pulse
//   words_written, illegal_cnt   : per-session counters (wrap / saturate)
module instr_encode_loader
  import mips_enc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written,
  output logic [CNT_W-1:0]  illegal_cnt
);

  state_e            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  words_reg;
  logic [CNT_W-1:0]  illegal_reg;

  enc_t              enc;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              wr_fire;

  always_comb begin
    enc = encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);
  end

  assign req_ready = (state_reg == ST_LOAD) & ~fifo_full;
  assign accept    = req_valid & req_ready;
  // Illegal requests are consumed but never reach the FIFO.
  assign push      = accept & enc.legal;
  assign imem_we   = ~fifo_empty & ((state_reg == ST_LOAD) | (state_reg == ST_DRAIN));
  assign wr_fire   = imem_we & imem_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (wr_fire),
    .wdata (enc.word),
    .rdata (imem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      words_reg   <= '0;
      illegal_reg <= '0;
    end else begin
      // Writes can only fire in LOAD/DRAIN, so this never collides with the
      // counter clear on the IDLE->LOAD transition.
      if (wr_fire) begin
        addr_reg  <= addr_reg + ADDR_W'(4);
        words_reg <= words_reg + CNT_W'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_LOAD;
            addr_reg    <= base_addr & ~ADDR_W'(3);
            words_reg   <= '0;
            illegal_reg <= '0;
          end
        end
        ST_LOAD: begin
          if (accept && !enc.legal && (illegal_reg != '1)) begin
            illegal_reg <= illegal_reg + CNT_W'(1);
          end
          if (accept && req_last) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // An empty FIFO means no write can be pending on the memory port.
          if (fifo_empty) state_reg <= ST_DONE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr     = addr_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);
  assign words_written = words_reg;
  assign illegal_cnt   = illegal_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
module tb_instr_encode_loader;
  import mips_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_last = 1'b0;
  logic [4:0]  req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done;
  logic [7:0]  words_written, illegal_cnt;

  int errors = 0;
  int checks = 0;

  logic [9:0]  got_addr[$], exp_addr[$];
  logic [31:0] got_data[$], exp_data[$];

  logic        prev_stall = 1'b0;
  logic [9:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[17];

  instr_encode_loader #(.ADDR_W(10), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .words_written(words_written), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Captures every memory write and checks hold-stability during stalls.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (prev_stall && imem_we) begin
        checks++;
        if (imem_addr !== prev_addr || imem_wdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got %h/%h want %h/%h", imem_addr, imem_wdata, prev_addr, prev_data);
        end
      end
      prev_stall = imem_we & ~imem_ready;
      prev_addr  = imem_addr;
      prev_data  = imem_wdata;
      if (imem_we && imem_ready && !rst) begin
        got_addr.push_back(imem_addr);
        got_data.push_back(imem_wdata);
        $display("write addr=%h data=%h", imem_addr, imem_wdata);
      end
    end
  end

  task automatic expect_word(input logic [9:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic begin_session(input logic [9:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    int n = 0;
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sa;
    req_imm = imm; req_target = tgt; req_last = last; req_valid = 1'b1;
    #2;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!req_ready) chk("req_accept_timeout", {31'd0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_last  = 1'b0;
    $display("request op=%0d last=%0b accepted", op, last);
  endtask

  task automatic wait_done(input int exp_words, input int exp_ill);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!done && n < 500);
    chk("done_pulse", {31'd0, done}, 1);
    chk("words_written", {24'd0, words_written}, exp_words);
    chk("illegal_cnt", {24'd0, illegal_cnt}, exp_ill);
    @(negedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("busy_after_done", {31'd0, busy}, 0);
  endtask

  task automatic check_writes();
    int n;
    chk("write_count", got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("wr_addr[%0d]", i), {22'd0, got_addr[i]}, {22'd0, exp_addr[i]});
      chk($sformatf("wr_data[%0d]", i), got_data[i], exp_data[i]);
    end
    got_addr.delete(); got_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  initial begin
    // Hand-encoded with rs=1 rt=2 rd=3 shamt=4 imm=8001 target=1234567
    vecs[0]  = '{OP_ADD,   32'h00221820};
    vecs[1]  = '{OP_SUB,   32'h00221822};
    vecs[2]  = '{OP_SUBU,  32'h00221823};
    vecs[3]  = '{OP_SRAV,  32'h00221807};
    vecs[4]  = '{OP_SRL,   32'h00021902};
    vecs[5]  = '{OP_SLTU,  32'h0022182B};
    vecs[6]  = '{OP_BLTZ,  32'h04208001};
    vecs[7]  = '{OP_BGEZ,  32'h04218001};
    vecs[8]  = '{OP_J,     32'h09234567};
    vecs[9]  = '{OP_ADDI,  32'h20228001};
    vecs[10] = '{OP_ADDIU, 32'h24228001};
    vecs[11] = '{OP_SLTI,  32'h28228001};
    vecs[12] = '{OP_XORI,  32'h38228001};
    vecs[13] = '{OP_LUI,   32'h3C028001};
    vecs[14] = '{OP_CLZ,   32'h70221820};
    vecs[15] = '{OP_CLO,   32'h70221821};
    vecs[16] = '{OP_SEB,   32'h7C021C20};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_imem_we", {31'd0, imem_we}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_addr", {22'd0, imem_addr}, 0);
    chk("rst_words", {24'd0, words_written}, 0);
    chk("rst_illegal", {24'd0, illegal_cnt}, 0);

    // Single ADD
    begin_session(10'h100);
    expect_word(10'h100, 32'h00221820);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done(1, 0);
    check_writes();

    // ADDI / LUI / J
    begin_session(10'h100);
    expect_word(10'h100, 32'h2004FFFF);
    expect_word(10'h104, 32'h3C051234);
    expect_word(10'h108, 32'h08000040);
    send(OP_ADDI, 5'd0, 5'd4, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    send(OP_LUI,  5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    send(OP_J,    5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b1);
    wait_done(3, 0);
    check_writes();

    // Every legal op, unused fields deliberately non-zero
    begin_session(10'h203);  // low bits must be cleared
    for (int i = 0; i < 17; i++) begin
      expect_word(10'h200 + 10'(4 * i), vecs[i].word);
      send(vecs[i].op, 5'd1, 5'd2, 5'd3, 5'd4, 16'h8001, 26'h1234567, (i == 16));
    end
    wait_done(17, 0);
    check_writes();

    // Back-pressure: 5 requests into a depth-4 FIFO with memory stalled
    imem_ready = 1'b0;
    begin_session(10'h040);
    for (int i = 0; i < 5; i++) expect_word(10'h040 + 10'(4 * i), 32'h20000000 | (i << 16) | i);
    fork
      begin
        for (int i = 0; i < 5; i++) send(OP_ADDI, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'h0, (i == 4));
      end
      begin
        repeat (10) @(negedge clk);
        #2;
        chk("full_req_ready", {31'd0, req_ready}, 0);
        chk("stall_we", {31'd0, imem_we}, 1);
        chk("stall_addr", {22'd0, imem_addr}, 32'h040);
        chk("stall_data", imem_wdata, 32'h20000000);
        @(negedge clk);
        imem_ready = 1'b1;
      end
    join
    wait_done(5, 0);
    check_writes();

    // Address wrap
    begin_session(10'h3FC);
    expect_word(10'h3FC, 32'h00021902);
    expect_word(10'h000, 32'h04210008);
    send(OP_SRL,  5'd0, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0);
    send(OP_BGEZ, 5'd1, 5'd0, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b1);
    wait_done(2, 0);
    check_writes();

    // Illegal op followed by CLO
    begin_session(10'h100);
    expect_word(10'h100, 32'h70201021);
    send(5'd20,  5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
    send(OP_CLO, 5'd1, 5'd0, 5'd2, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done(1, 1);
    check_writes();

    // Session with no legal words: last on an illegal request
    begin_session(10'h100);
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done(0, 1);
    check_writes();

    // Reset with words queued
    imem_ready = 1'b0;
    begin_session(10'h080);
    for (int i = 0; i < 3; i++) send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    #1;
    chk("queued_we", {31'd0, imem_we}, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_we", {31'd0, imem_we}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_addr", {22'd0, imem_addr}, 0);
    chk("mid_rst_data", imem_wdata, 0);
    chk("mid_rst_words", {24'd0, words_written}, 0);
    rst = 1'b0;
    imem_ready = 1'b1;
    check_writes();

    // New session after reset
    begin_session(10'h080);
    expect_word(10'h080, 32'h00221820);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done(1, 0);
    check_writes();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Instruction encoder/loader: the encode side of the MIPS decode path. It accepts symbolic instruction requests over a valid/ready handshake and packs each one into a 32-bit MIPS word.
- Encoded words are buffered in a small FIFO and written sequentially into instruction memory from a latched base address.
- Used for program load and for the pipeline test bench. It is the producer of the exact opcode/funct encodings the decode controller consumes.

Parameters:
- ADDR_W, 10, byte-address width of the instruction-memory write port
- DEPTH, 4, FIFO depth in words (power of two, >=2)
- CNT_W, 8, width of the written-word and illegal-request counters

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: begin a load session
- base_addr  in  ADDR_W  first write address, latched on an accepted start; low 2 bits are forced to 0
- req_valid  in  1  request valid
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_last  in  1  final request of the session
- req_op  in  5  symbolic op (enum in package)
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_shamt  in  5  shift amount
- req_imm  in  16  immediate / branch offset
- req_target  in  26  jump target
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts the write when imem_we & imem_ready
- imem_addr  out  ADDR_W  word write address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- words_written  out  CNT_W  words written this session (wraps)
- illegal_cnt  out  CNT_W  illegal requests this session (saturates)

Behaviour:
- Reset: state IDLE, FIFO empty, address=0, all outputs 0.
- FSM states:
  - IDLE: start -> LOAD. On the transition, latch base_addr and clear both counters.
  - LOAD: on acceptance of a request with req_last -> DRAIN.
  - DRAIN: FIFO empty and no write in flight -> DONE.
  - DONE: for exactly one cycle, done=1, then -> IDLE.
- start outside IDLE is ignored.
- busy=1 in LOAD, DRAIN and DONE.
- req_ready = (state==LOAD) & ~fifo_full. A full FIFO does not accept a push, even when a pop occurs in the same cycle.
- Encoding is combinational from the req_* fields and is pushed into the FIFO on acceptance.
- Latency: a word accepted in cycle N is presented on imem_* in cycle N+1 at the earliest.
- imem_we = ~fifo_empty & state in {LOAD, DRAIN}.
  - imem_wdata is the FIFO head. imem_addr is the current address.
  - Both hold stable while imem_we & ~imem_ready.
- On imem_we & imem_ready:
  - pop the FIFO
  - address += 4, wrapping modulo 2^ADDR_W
  - words_written += 1, wrapping
- Encodings, written as op[31:26] rs rt rd shamt funct; unused fields are 0:
  - ADD 000000 rs rt rd 0 100000
  - SUB funct 100010
  - SUBU funct 100011
  - SLTU funct 101011
  - SRAV 000000 rs rt rd 0 000111
  - SRL 000000 0 rt rd shamt 000010
  - BLTZ 000001 rs 00000 imm
  - BGEZ 000001 rs 00001 imm
  - J 000010 target
  - ADDI 001000 rs rt imm
  - ADDIU 001001
  - SLTI 001010
  - XORI 001110
  - LUI 001111 0 rt imm
  - CLZ 011100 rs rt rd 0 100000
  - CLO 011100 rs rt rd 0 100001
  - SEB 011111 0 rt rd 10000 100000
- Illegal op (enum 17..31):
  - The request is accepted, nothing is pushed, and illegal_cnt increments, saturating at all-ones.
  - req_last on an illegal request still ends LOAD.
- A session with zero legal words goes LOAD -> DRAIN -> DONE with no writes.
- Simultaneous push and pop when not full: both happen, occupancy unchanged.
- rst mid-session: FIFO is flushed, pending words are lost, and all outputs return to reset values the next cycle. No done is pulsed.

Decomposition:
- Package mips_enc_pkg holds:
  - the op enum: ADD=0, SUB, SUBU, SRAV, SRL, SLTU, BLTZ, BGEZ, J, ADDI, ADDIU, SLTI, XORI, LUI, CLZ, CLO, SEB=16
  - opcode and funct localparams
  - the FSM state typedef
- One sub-module, instr_fifo: synchronous FIFO, DEPTH x 32, with full/empty flags and push/pop.

Test Plan:
- start base=0x100; ADD rs=1 rt=2 rd=3 (last); imem_ready=1 -> one write, addr 0x100, data 0x00221820; done pulses; words_written=1.
- Sequence ADDI rs=0 rt=4 imm=0xFFFF, LUI rt=5 imm=0x1234, J target=0x40 (last) -> 0x2004FFFF @0x100, 0x3C051234 @0x104, 0x08000040 @0x108.
- imem_ready=0 while 5 requests are offered, DEPTH=4 -> req_ready drops after 4 pushes and imem_addr/imem_wdata stay stable. Release imem_ready -> all 5 words are written in order.
- base=0x3FC, 2 requests (SRL rt=2 rd=3 shamt=4; BGEZ rs=1 imm=8) -> 0x00021902 @0x3FC, 0x04210008 @0x000 (wrap).
- req_op=20, then CLO rs=1 rt=0 rd=2 (last) -> illegal_cnt=1, single write 0x70201021.
- rst asserted with 3 words queued -> next cycle imem_we=0, busy=0, counters=0; a new start works normally.
